// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO behind the UART receiver: in-order buffering, occupancy
// status for flow control and sticky overflow/underflow error flags.
module uart_rx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int AF_LEVEL   = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clr_err
);

    localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_CNT   = (ADDR_WIDTH+1)'(AF_LEVEL);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic                  wr_acc, rd_acc;

    // Status is decoded from the registered count only, so it is glitch-free
    // relative to the clock and full/empty are mutually exclusive by construction.
    assign empty       = (count == '0);
    assign full        = (count == FULL_CNT);
    assign almost_full = (count >= AF_CNT);

    // A read never frees room for a same-cycle write, and a write is never
    // bypassed to a same-cycle read: both decisions use pre-edge status.
    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc)
            mem[wr_ptr] <= wr_data;
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc)
                rd_ptr <= rd_ptr + 1'b1;
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_acc;
            if (rd_acc)
                rd_data <= mem[rd_ptr];
        end
    end

    // New error events take priority over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (overflow  && !clr_err) || (wr_en && full);
            underflow <= (underflow && !clr_err) || (rd_en && empty);
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed plus randomized bench for uart_rx_fifo, checked every cycle against
// a queue-based reference model.
module tb_uart_rx_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int AFL   = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_en = 1'b0;
    logic          clr_err = 1'b0;
    logic [DW-1:0] rd_data;
    logic          rd_valid, empty, full, almost_full, overflow, underflow;
    logic [AW:0]   count;

    uart_rx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .AF_LEVEL(AFL)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid), .empty(empty), .full(full),
        .almost_full(almost_full), .count(count), .overflow(overflow),
        .underflow(underflow), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    // reference model state
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_rd_data = '0;
    logic          m_rd_valid = 1'b0;
    logic          m_ovf = 1'b0;
    logic          m_unf = 1'b0;
    int            n_checks = 0;
    int            n_pass = 0;
    int            n_fail = 0;
    int            max_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string step);
        chk({step, " rd_valid"},    32'(rd_valid),    32'(m_rd_valid));
        chk({step, " rd_data"},     32'(rd_data),     32'(m_rd_data));
        chk({step, " count"},       32'(count),       32'(q.size()));
        chk({step, " empty"},       32'(empty),       32'(q.size() == 0));
        chk({step, " full"},        32'(full),        32'(q.size() == DEPTH));
        chk({step, " almost_full"}, 32'(almost_full), 32'(q.size() >= AFL));
        chk({step, " overflow"},    32'(overflow),    32'(m_ovf));
        chk({step, " underflow"},   32'(underflow),   32'(m_unf));
    endtask

    // Drive one cycle, advance the model by the spec rules, then check outputs.
    task automatic cyc(input string step, input logic r, input logic w, input logic [DW-1:0] d,
                       input logic rd, input logic ce);
        bit was_full, was_empty;
        rst = r; wr_en = w; wr_data = d; rd_en = rd; clr_err = ce;
        @(posedge clk);
        was_full  = (q.size() == DEPTH);
        was_empty = (q.size() == 0);
        m_rd_valid = 1'b0;
        if (r) begin
            q.delete();
            m_rd_data = '0;
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            m_ovf = (m_ovf && !ce) || (w && was_full);
            m_unf = (m_unf && !ce) || (rd && was_empty);
            if (rd && !was_empty) begin
                m_rd_data  = q.pop_front();
                m_rd_valid = 1'b1;
            end
            if (w && !was_full)
                q.push_back(d);
        end
        #1;
        chk_all(step);
        if (q.size() > max_cnt) max_cnt = q.size();
    endtask

    initial begin
        // reset with a write strobe active
        cyc("reset0", 1, 1, 8'hAA, 0, 0);
        cyc("reset1", 1, 1, 8'hAA, 0, 0);

        // basic order
        cyc("basic_w", 0, 1, 8'h41, 0, 0);
        cyc("basic_w", 0, 1, 8'h42, 0, 0);
        cyc("basic_w", 0, 1, 8'h43, 0, 0);
        for (int i = 0; i < 4; i++) cyc("basic_r", 0, 0, 0, i < 3, 0);

        // fill, overflow, drain, clear
        for (int i = 0; i < 16; i++) cyc("fill", 0, 1, 8'(i), 0, 0);
        cyc("ovf_w", 0, 1, 8'hFF, 0, 0);
        cyc("ovf_wr", 0, 1, 8'hFF, 1, 0);
        cyc("ovf_fill", 0, 1, 8'h0F, 0, 0);
        for (int i = 0; i < 17; i++) cyc("drain", 0, 0, 0, i < 16, 0);
        cyc("clr_ovf", 0, 0, 0, 0, 1);

        // underflow, then clear racing a new underflow
        cyc("unf", 0, 0, 0, 1, 0);
        cyc("unf_hold", 0, 0, 0, 0, 0);
        cyc("unf_clr_set", 0, 0, 0, 1, 1);
        cyc("unf_clr", 0, 0, 0, 0, 1);
        cyc("unf_w_same", 0, 1, 8'h5A, 1, 0);
        cyc("unf_rd", 0, 0, 0, 1, 1);
        cyc("idle", 0, 0, 0, 0, 0);

        // wrap with concurrent ops
        for (int i = 0; i < 10; i++) cyc("wrap_w", 0, 1, 8'(8'h80 + i), 0, 0);
        for (int i = 0; i < 10; i++) cyc("wrap_r", 0, 0, 0, 1, 0);
        max_cnt = 0;
        for (int i = 0; i < 10; i++) cyc("wrap_wr", 0, 1, 8'(8'h10 + i), i > 0, 0);
        cyc("wrap_tail", 0, 0, 0, 1, 0);
        cyc("wrap_end", 0, 0, 0, 0, 0);
        chk("wrap max_count", 32'(max_cnt <= 1), 32'd1);

        // reset mid-operation
        for (int i = 0; i < 5; i++) cyc("mid_w", 0, 1, 8'(8'hC0 + i), 0, 0);
        cyc("mid_rst", 1, 0, 0, 1, 0);
        cyc("mid_rd", 0, 0, 0, 1, 0);
        cyc("mid_end", 0, 0, 0, 0, 0);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            int ph;
            logic w, r;
            ph = (i / 100) % 3;
            w = ($urandom_range(99) < (ph == 0 ? 70 : ph == 1 ? 30 : 50));
            r = ($urandom_range(99) < (ph == 0 ? 30 : ph == 1 ? 70 : 50));
            cyc("rand", ($urandom_range(99) < 2), w, 8'($urandom), r, ($urandom_range(99) < 8));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
